// File: rtl/pingpong_write_packer.sv
// Write-side front end for the dual-clock ping-pong buffer: packs narrow valid/ready beats into
// WIDTH-bit words and feeds the buffer's wen/data_in, stalling on its full flag.
module pingpong_write_packer #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             wclk,
  input  logic             reset_n,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [IN_W-1:0]  s_data_i,
  input  logic             s_last_i,
  input  logic             full_i,
  output logic             wen_o,
  output logic [WIDTH-1:0] data_out_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int unsigned RATIO = WIDTH / IN_W;
  localparam int unsigned BcntW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BcntW-1:0] LastBeat = BcntW'(RATIO - 1);

  typedef enum logic {StFill, StDone} pack_state_e;

  pack_state_e      state_q, state_d;
  logic [WIDTH-1:0] pack_q, pack_d;
  logic [BcntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic slot_free;
  logic transfer;
  logic accept;
  logic word_end;
  logic wr;

  // The output slot can take a new word if it is empty or is being written this cycle.
  assign slot_free = !out_valid_q || !full_i;
  assign transfer  = (state_q == StDone) && slot_free;
  assign s_ready_o = (state_q == StFill) || slot_free;
  assign accept    = s_valid_i && s_ready_o;
  assign word_end  = (beat_cnt_q == LastBeat) || s_last_i;
  assign wr        = out_valid_q && !full_i;

  // Pack stage: a transfer clears pack_q first, so a beat accepted in the same cycle lands in a
  // zeroed word and unwritten lanes of a flushed word read as zero.
  always_comb begin
    pack_d     = pack_q;
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (transfer) begin
      pack_d  = '0;
      state_d = StFill;
    end
    if (accept) begin
      pack_d[int'(beat_cnt_q) * IN_W +: IN_W] = s_data_i;
      if (word_end) begin
        state_d    = StDone;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // Output stage: out_q only moves on a transfer, which cannot happen while held by full.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (transfer) begin
      out_d       = pack_q;
      out_valid_d = 1'b1;
    end else if (wr) begin
      out_valid_d = 1'b0;
    end
    word_cnt_d = word_cnt_q + CNT_W'(wr);
  end

  always_ff @(posedge wclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StFill;
      pack_q      <= '0;
      beat_cnt_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pack_q      <= pack_d;
      beat_cnt_q  <= beat_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign wen_o      = wr;
  assign data_out_o = out_q;
  assign busy_o     = (state_q == StDone) || out_valid_q || (beat_cnt_q != '0);
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_pingpong_write_packer.sv
// Directed bench for pingpong_write_packer: a per-cycle vector table for streaming and flush,
// plus sequences for full back-pressure, reset mid-word and word_cnt wrap (RATIO=1 instance).
module tb_pingpong_write_packer;

  logic        wclk = 1'b0;
  logic        reset_n;
  logic        s_valid, s_ready, s_last, full, wen, busy;
  logic [7:0]  s_data;
  logic [31:0] data_out;
  logic [15:0] word_cnt;

  logic        v1, ready1, last1, full1, wen1, busy1;
  logic [31:0] d1, dout1;
  logic [15:0] cnt1;

  always #5 wclk = ~wclk;

  pingpong_write_packer #(.IN_W(8), .WIDTH(32), .CNT_W(16)) u_dut (
    .wclk       (wclk),
    .reset_n    (reset_n),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .s_last_i   (s_last),
    .full_i     (full),
    .wen_o      (wen),
    .data_out_o (data_out),
    .busy_o     (busy),
    .word_cnt_o (word_cnt)
  );

  pingpong_write_packer #(.IN_W(32), .WIDTH(32), .CNT_W(16)) u_dut1 (
    .wclk       (wclk),
    .reset_n    (reset_n),
    .s_valid_i  (v1),
    .s_ready_o  (ready1),
    .s_data_i   (d1),
    .s_last_i   (last1),
    .full_i     (full1),
    .wen_o      (wen1),
    .data_out_o (dout1),
    .busy_o     (busy1),
    .word_cnt_o (cnt1)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        last;
    logic        f;
    logic        rdy;
    logic        wen;
    logic [31:0] data;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t        vecs[16];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] wr_q[$];
  logic [31:0] exp_word;
  int          nwr1, stall1, derr1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle on the 8-bit instance: drive at negedge, sample mid-low phase, log writes.
  task automatic cyc(input logic v, input logic [7:0] d, input logic last, input logic f,
                     output logic acc);
    s_valid = v; s_data = d; s_last = last; full = f;
    #2;
    acc = v && s_ready;
    if (wen) wr_q.push_back(data_out);
    @(negedge wclk);
  endtask

  // One cycle on the RATIO=1 instance; written words must be 0,1,2,... in order.
  task automatic cyc1(input logic v, input logic [31:0] d);
    v1 = v; d1 = d; last1 = 1'b0; full1 = 1'b0;
    #2;
    if (v && !ready1) stall1++;
    if (wen1) begin
      if (dout1 !== exp_word) derr1++;
      exp_word = exp_word + 1;
      nwr1++;
    end
    @(negedge wclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   idx;
    logic [15:0] cnt0;

    //         v     d      last  f     rdy   wen   data           busy  cnt
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 16'd0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd0};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd0};
    vecs[5]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211,  1'b1, 16'd0};
    vecs[6]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd1};
    vecs[7]  = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h88776655,  1'b1, 16'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 16'd2};
    vecs[11] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 16'd2};
    vecs[12] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd2};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd2};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000BBAA,  1'b1, 16'd2};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 16'd3};

    reset_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; full = 1'b0;
    v1 = 1'b0; d1 = '0; last1 = 1'b0; full1 = 1'b0;
    repeat (2) @(negedge wclk);
    reset_n = 1'b1;
    @(negedge wclk);
    #2;
    chk("reset s_ready", 32'(s_ready), 32'd1);
    chk("reset wen", 32'(wen), 32'd0);
    chk("reset data_out", data_out, 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset word_cnt", 32'(word_cnt), 32'd0);
    @(negedge wclk);

    // Streaming and flush, cycle by cycle.
    for (int i = 0; i < 16; i++) begin
      s_valid = vecs[i].v; s_data = vecs[i].d; s_last = vecs[i].last; full = vecs[i].f;
      #2;
      chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d wen", i), 32'(wen), 32'(vecs[i].wen));
      if (vecs[i].wen) chk($sformatf("vec%0d data_out", i), data_out, vecs[i].data);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d word_cnt", i), 32'(word_cnt), 32'(vecs[i].cnt));
      @(negedge wclk);
    end

    // Full held high: two words buffered, then back-pressure; release drains in order.
    wr_q.delete();
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 8'(idx + 1), 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("full accepted beats", 32'(idx), 32'd8);
    chk("full no wen", 32'(wr_q.size()), 32'd0);
    s_valid = 1'b1; full = 1'b1;
    #1;
    chk("full s_ready low", 32'(s_ready), 32'd0);
    for (int k = 0; k < 40 && (idx < 12 || wr_q.size() < 3); k++) begin
      cyc(idx < 12, 8'(idx + 1), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("full release words", 32'(wr_q.size()), 32'd3);
    for (int w = 0; w < 3 && w < wr_q.size(); w++)
      chk($sformatf("full word%0d", w), wr_q[w],
          {8'(4 * w + 4), 8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1)});
    s_valid = 1'b0; full = 1'b0;
    #1;
    chk("full drained busy", 32'(busy), 32'd0);
    @(negedge wclk);

    // Full toggling every cycle during a continuous stream.
    wr_q.delete();
    cnt0 = word_cnt;
    idx = 0;
    for (int k = 0; k < 100 && (idx < 16 || wr_q.size() < 4); k++) begin
      cyc(idx < 16, 8'(8'h20 + idx), 1'b0, k[0], acc);
      if (acc) idx++;
    end
    chk("toggle words", 32'(wr_q.size()), 32'd4);
    for (int w = 0; w < 4 && w < wr_q.size(); w++)
      chk($sformatf("toggle word%0d", w), wr_q[w],
          {8'(8'h23 + 4 * w), 8'(8'h22 + 4 * w), 8'(8'h21 + 4 * w), 8'(8'h20 + 4 * w)});
    chk("toggle word_cnt delta", 32'(16'(word_cnt - cnt0)), 32'd4);

    // Reset mid-word discards the partial data.
    wr_q.delete();
    cyc(1'b1, 8'h51, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h52, 1'b0, 1'b0, acc);
    s_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset wen", 32'(wen), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset s_ready", 32'(s_ready), 32'd1);
    chk("midreset word_cnt", 32'(word_cnt), 32'd0);
    @(negedge wclk);
    reset_n = 1'b1;
    idx = 0;
    for (int k = 0; k < 20 && (idx < 4 || wr_q.size() < 1); k++) begin
      cyc(idx < 4, 8'(8'h61 + idx), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, acc);
    chk("midreset words", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) chk("midreset clean word", wr_q[0], 32'h64636261);

    // RATIO=1 instance: one word per cycle and word_cnt wrap.
    exp_word = 0; nwr1 = 0; stall1 = 0; derr1 = 0;
    for (int i = 0; i < 65535; i++) cyc1(1'b1, 32'(i));
    chk("ratio1 throughput", 32'(nwr1), 32'd65533);
    for (int k = 0; k < 10 && nwr1 < 65535; k++) cyc1(1'b0, 32'h0);
    chk("ratio1 stalls", 32'(stall1), 32'd0);
    chk("ratio1 data order", 32'(derr1), 32'd0);
    chk("ratio1 word_cnt max", 32'(cnt1), 32'h0000FFFF);
    cyc1(1'b1, 32'd65535);
    for (int k = 0; k < 10 && nwr1 < 65536; k++) cyc1(1'b0, 32'h0);
    chk("ratio1 word_cnt wrap", 32'(cnt1), 32'd0);
    chk("ratio1 idle busy", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
